mdu_hilo_iter: RTL and testbench
================================

Name: mdu_hilo_iter

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Replaces the single-cycle HI/LO multiply path with a multi-cycle engine:
  - signed and unsigned multiply and divide;
  - MTHI/MTLO writes;
  - start/busy/done handshake that the core uses to stall on HI/LO reads and on new MDU ops.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  request; sampled only at posedge while busy=0
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
- src_a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- src_b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  engine iterating; core stalls MFHI/MFLO and new MDU ops
- done  out  1  one-cycle pulse: hi/lo updated at the same edge
- div_by_zero  out  1  valid with done; set when the divisor was 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset and clock:
  - Reset is asynchronous, active-high; clock is clk, rising edge.
  - While reset is high: hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM in IDLE.
  - Asserting reset mid-operation aborts the operation. No partial result reaches hi/lo.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 with op MULT/MULTU latches the operand magnitudes (abs for signed ops) and result sign, clears the counter and goes to MUL. busy=1 from that edge.
  - DIV/DIVU with src_b!=0 does the same and goes to DIV.
  - DIV/DIVU with src_b=0 stays in IDLE. Next edge: lo=all ones, hi=src_a, done=1, div_by_zero=1, busy never set.
  - MTHI/MTLO writes hi or lo at the next edge with done=1, busy never set.
- MUL:
  - Radix-2 shift-add, one bit per cycle, over a 2*WIDTH accumulator.
  - After WIDTH iterations go to FIX.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - After WIDTH iterations go to FIX.
- FIX:
  - Applies the two's-complement sign correction.
  - Multiply: {hi,lo} = signed/unsigned 2*WIDTH product.
  - Divide: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend.
  - Writes hi/lo, pulses done, drops busy, returns to IDLE.
- Latency: accept edge E0, then hi/lo written and done=1 at edge E0+WIDTH+1. busy is high for exactly WIDTH+1 cycles.
- Signed overflow: DIV of -2^(WIDTH-1) by -1 gives lo=-2^(WIDTH-1), hi=0, div_by_zero=0.
- Ignored requests (no state change):
  - start while busy=1;
  - op 110/111 when MDU_MADD_EN is undefined.
- div_by_zero is cleared on every done that is not a divide by zero. It holds its value between done pulses.
- hi/lo are stable at all times except on the done edge.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 110 MADD: {hi,lo} += signed product.
  - op 111 MSUB: {hi,lo} -= signed product.
  - The multiply path runs as usual; FIX adds or subtracts the product into the {hi,lo} value captured at accept. Same WIDTH+1 latency. Result wraps modulo 2^(2*WIDTH).
- Undefined: ops 110/111 are ignored as above, and no accumulate adder is built.

Test Plan (WIDTH=32):
- MULT src_a=-3 (FFFFFFFD), src_b=7 -> after 33 cycles: done=1, hi=FFFFFFFF, lo=FFFFFFEB; busy high for exactly 33 cycles.
- DIVU 100/7 -> lo=0000000E, hi=00000002. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- DIV 1234/0 -> done one cycle after accept, lo=FFFFFFFF, hi=000004D2, div_by_zero=1, busy never high. A following MTLO 5 -> lo=5, div_by_zero=0.
- MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001. A second start with op=MTHI at cycle 10 of the multiply is ignored: final hi=FFFFFFFE.
- Reset asserted at cycle 15 of a DIVU (asynchronously, between edges) -> busy, done, hi, lo read 0 immediately. A subsequent DIVU 9/3 completes normally: lo=3, hi=0.
- With MDU_MADD_EN: MTHI 0, MTLO 10, then MADD 4*5 -> lo=0000001E, hi=0. Then MSUB 2*20 -> {hi,lo}=FFFFFFFF_FFFFFFF6. Without the macro the same MADD is ignored: lo stays 10, no done.

Source files
------------

// File: rtl/mdu_hilo_iter.sv
// rtl/mdu_hilo_iter.sv - iterative multiply/divide unit owning HI/LO; MADD/MSUB built only when MDU_MADD_EN is defined
module mdu_hilo_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

   stateT              state, stateNext;
   logic [CNT_W-1:0]   cnt;
   // Multiplicand for MUL, divisor for DIV.
   logic [WIDTH-1:0]   mcand;
   // MUL: {partial product, remaining multiplier bits}; DIV: {remainder, dividend/quotient bits}.
   logic [2*WIDTH-1:0] acc;
   logic               divMode;
   logic               negRes;
   logic               negRem;
`ifdef MDU_MADD_EN
   logic               accEn;
   logic               accSub;
`endif

   logic               isSigned, isMulOp, isDivOp, divZero, aNeg, bNeg, lastIter;
   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH:0]     mulSum, divShift, divDiff;
   logic               divGe;
   logic [2*WIDTH-1:0] mulNext, divNext, prodFix;
   logic [WIDTH-1:0]   quoFix, remFix;

   assign isSigned = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
`ifdef MDU_MADD_EN
   assign isMulOp  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
`else
   assign isMulOp  = (op == OP_MULT) || (op == OP_MULTU);
`endif
   assign isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
   assign divZero  = (src_b == '0);
   assign aNeg     = isSigned && src_a[WIDTH-1];
   assign bNeg     = isSigned && src_b[WIDTH-1];
   assign magA     = aNeg ? -src_a : src_a;
   assign magB     = bNeg ? -src_b : src_b;
   assign lastIter = (cnt == CNT_W'(WIDTH - 1));
   assign busy     = (state != IDLE);

   // One shift-add / restoring-subtract step plus the final sign correction.
   always_comb begin
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
      mulNext  = {mulSum, acc[WIDTH-1:1]};
      divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      divDiff  = divShift - {1'b0, mcand};
      divGe    = !divDiff[WIDTH];
      divNext  = {(divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]), acc[WIDTH-2:0], divGe};
      prodFix  = negRes ? -acc : acc;
      quoFix   = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remFix   = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Next-state decode; requests are only looked at in IDLE.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (start && isMulOp)
               stateNext = MUL;
            else if (start && isDivOp && !divZero)
               stateNext = DIV;
         end
         MUL:     if (lastIter) stateNext = FIX;
         DIV:     if (lastIter) stateNext = FIX;
         FIX:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State, datapath and HI/LO registers; hi/lo change only on the done edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         mcand       <= '0;
         acc         <= '0;
         divMode     <= 1'b0;
         negRes      <= 1'b0;
         negRem      <= 1'b0;
`ifdef MDU_MADD_EN
         accEn       <= 1'b0;
         accSub      <= 1'b0;
`endif
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         state <= stateNext;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start && isMulOp) begin
                  mcand   <= magA;
                  acc     <= {{WIDTH{1'b0}}, magB};
                  cnt     <= '0;
                  divMode <= 1'b0;
                  negRes  <= aNeg ^ bNeg;
                  negRem  <= 1'b0;
`ifdef MDU_MADD_EN
                  accEn   <= (op == OP_MADD) || (op == OP_MSUB);
                  accSub  <= (op == OP_MSUB);
`endif
               end else if (start && isDivOp && !divZero) begin
                  mcand   <= magB;
                  acc     <= {{WIDTH{1'b0}}, magA};
                  cnt     <= '0;
                  divMode <= 1'b1;
                  negRes  <= aNeg ^ bNeg;
                  negRem  <= aNeg;
`ifdef MDU_MADD_EN
                  accEn   <= 1'b0;
                  accSub  <= 1'b0;
`endif
               end else if (start && isDivOp) begin
                  lo          <= '1;
                  hi          <= src_a;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
               end else if (start && (op == OP_MTHI)) begin
                  hi          <= src_a;
                  done        <= 1'b1;
                  div_by_zero <= 1'b0;
               end else if (start && (op == OP_MTLO)) begin
                  lo          <= src_a;
                  done        <= 1'b1;
                  div_by_zero <= 1'b0;
               end
            end
            MUL: begin
               acc <= mulNext;
               cnt <= cnt + CNT_W'(1);
            end
            DIV: begin
               acc <= divNext;
               cnt <= cnt + CNT_W'(1);
            end
            FIX: begin
               if (divMode) begin
                  hi <= remFix;
                  lo <= quoFix;
               end
`ifdef MDU_MADD_EN
               // hi/lo cannot change while busy, so they still hold the value seen at accept.
               else if (accEn) begin
                  if (accSub) {hi, lo} <= {hi, lo} - prodFix;
                  else        {hi, lo} <= {hi, lo} + prodFix;
               end
`endif
               else begin
                  {hi, lo} <= prodFix;
               end
               done        <= 1'b1;
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_hilo_iter.sv
// tb/tb_mdu_hilo_iter.sv - self-checking bench for mdu_hilo_iter against an arithmetic reference model
module tb_mdu_hilo_iter;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] src_a, src_b;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] mHi, mLo;
   logic         mDbz;

   mdu_hilo_iter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: updates mHi/mLo/mDbz from plain arithmetic; returns op class.
   task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit ignored, output bit multi);
      longint      sa, sb, q, r;
      logic [63:0] p, hl;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ignored = 1'b0;
      multi   = 1'b0;
      case (o)
         3'd0: begin p = 64'(sa * sb); {mHi, mLo} = p; mDbz = 1'b0; multi = 1'b1; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; {mHi, mLo} = p; mDbz = 1'b0; multi = 1'b1; end
         3'd2, 3'd3: begin
            if (b == 0) begin
               mLo = '1; mHi = a; mDbz = 1'b1;
            end else if (o == 3'd2) begin
               q = sa / sb; r = sa % sb;
               mLo = q[W-1:0]; mHi = r[W-1:0]; mDbz = 1'b0; multi = 1'b1;
            end else begin
               mLo = a / b; mHi = a % b; mDbz = 1'b0; multi = 1'b1;
            end
         end
         3'd4: begin mHi = a; mDbz = 1'b0; end
         3'd5: begin mLo = a; mDbz = 1'b0; end
         default: begin
`ifdef MDU_MADD_EN
            p  = 64'(sa * sb);
            hl = {mHi, mLo};
            hl = (o == 3'd6) ? hl + p : hl - p;
            {mHi, mLo} = hl;
            mDbz  = 1'b0;
            multi = 1'b1;
`else
            hl = 64'd0;
            p  = hl;
            ignored = 1'b1;
`endif
         end
      endcase
   endtask

   // Issue one request and compare timing and results with the model.
   task automatic runOp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      bit ignored, multi, sawDone;
      int k, busyCnt, expLat;
      model(o, a, b, ignored, multi);
      @(negedge clk);
      op = o; src_a = a; src_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (ignored) begin
         sawDone = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (done || busy) sawDone = 1'b1;
            @(negedge clk);
         end
         check({tag, "_ignored_activity"}, 64'(sawDone), 64'd0);
         check({tag, "_ignored_hilo"}, {hi, lo}, {mHi, mLo});
      end else begin
         k = 0; busyCnt = 0;
         while (!done && k < 60) begin
            if (busy) busyCnt++;
            @(negedge clk);
            k++;
         end
         expLat = multi ? W + 1 : 0;
         check({tag, "_latency"}, 64'(k), 64'(expLat));
         check({tag, "_busycycles"}, 64'(busyCnt), 64'(expLat));
         check({tag, "_hi"}, 64'(hi), 64'(mHi));
         check({tag, "_lo"}, 64'(lo), 64'(mLo));
         check({tag, "_dbz"}, 64'(div_by_zero), 64'(mDbz));
         @(negedge clk);
         check({tag, "_donepulse"}, 64'(done), 64'd0);
      end
   endtask

   initial begin
      int k;
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
      mHi = '0; mLo = '0; mDbz = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", {busy, done, div_by_zero, hi, lo}, 67'd0);
      reset = 1'b0;
      @(negedge clk);

      runOp(3'd0, 32'hFFFFFFFD, 32'd7, "mult_neg3x7");
      check("mult_neg3x7_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      runOp(3'd3, 32'd100, 32'd7, "divu_100_7");
      check("divu_100_7_const", {hi, lo}, 64'h00000002_0000000E);
      runOp(3'd2, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      check("div_m7_2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      check("div_ovf_const", {hi, lo, div_by_zero}, {64'h00000000_80000000, 1'b0});
      runOp(3'd2, 32'd1234, 32'd0, "div_zero");
      check("div_zero_const", {hi, lo, div_by_zero}, {64'h000004D2_FFFFFFFF, 1'b1});
      runOp(3'd5, 32'd5, 32'd0, "mtlo_5");
      check("mtlo_5_const", {lo, div_by_zero}, {32'd5, 1'b0});

      // MULTU with an MTHI request arriving mid-operation; the request must be dropped.
      @(negedge clk);
      op = 3'd1; src_a = '1; src_b = '1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; k = 0;
      repeat (9) begin @(negedge clk); k++; end
      op = 3'd4; src_a = 32'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0; k++;
      while (!done && k < 60) begin @(negedge clk); k++; end
      check("multu_max_latency", 64'(k), 64'(W + 1));
      check("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
      mHi = 32'hFFFFFFFE; mLo = 32'h1; mDbz = 1'b0;

      // Asynchronous reset in the middle of a DIVU.
      @(negedge clk);
      op = 3'd3; src_a = 32'hDEADBEEF; src_b = 32'h77; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset", {busy, done, div_by_zero, hi, lo}, 67'd0);
      @(negedge clk);
      reset = 1'b0;
      mHi = '0; mLo = '0; mDbz = 1'b0;
      runOp(3'd3, 32'd9, 32'd3, "divu_9_3");
      check("divu_9_3_const", {hi, lo}, 64'h00000000_00000003);

      runOp(3'd4, 32'd0, 32'd0, "mthi_0");
      runOp(3'd5, 32'd10, 32'd0, "mtlo_10");
`ifdef MDU_MADD_EN
      runOp(3'd6, 32'd4, 32'd5, "madd_4x5");
      check("madd_4x5_const", {hi, lo}, 64'h00000000_0000001E);
      runOp(3'd7, 32'd2, 32'd20, "msub_2x20");
      check("msub_2x20_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF6);
`else
      runOp(3'd6, 32'd4, 32'd5, "madd_off");
      check("madd_off_const", {hi, lo}, 64'h00000000_0000000A);
`endif

      // Randomized mix of all opcodes and operand shapes.
      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
         runOp(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
